// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder.
//   - RV32 load/store funct3 size/sign encodings
//   - responder FSM state type
//   - default byte address of RAM word 0
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/data_mem_resp_if.sv
// Load/store request/response handshake between the core (master) and the
// memory responder (slave).
//   req_valid/req_ready       request handshake
//   req_wen                   1 = store, 0 = load
//   req_funct3                RV32 size/sign code
//   req_addr                  byte address
//   req_wdata                 right-aligned store data
//   resp_valid/resp_ready     response handshake
//   resp_rdata                extended load data (0 for stores/faults)
//   resp_err                  access fault
interface data_mem_resp_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wen, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wen, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for RV32 sub-word accesses (purely combinational).
//   i_funct3     size/sign code (undefined codes behave as a word)
//   i_addr_lo    low two address bits
//   i_wdata      right-aligned store data
//   i_raw_word   word read from RAM
//   o_be         byte enables for the store
//   o_wdata      store data replicated onto every lane of its size
//   o_rdata      selected lane, sign- or zero-extended to 32 bits
//   o_misalign   half not on a 2-byte boundary or word not on a 4-byte boundary
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_raw_word,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_signed;

  assign w_byte   = i_raw_word[{i_addr_lo, 3'b000} +: 8];
  // Half lane comes from addr[1] only, so a misaligned half silently aligns down.
  assign w_half   = i_addr_lo[1] ? i_raw_word[31:16] : i_raw_word[15:0];
  assign w_signed = ~i_funct3[2];

  always_comb begin
    o_be       = 4'b1111;
    o_wdata    = i_wdata;
    o_rdata    = i_raw_word;
    o_misalign = 1'b0;
    unique case (i_funct3)
      F3_B, F3_BU: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{w_signed & w_byte[7]}}, w_byte};
      end
      F3_H, F3_HU: begin
        o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata    = {2{i_wdata[15:0]}};
        o_rdata    = {{16{w_signed & w_half[15]}}, w_half};
        o_misalign = i_addr_lo[0];
      end
      default: begin
        // Word, and every undefined code, takes the whole word.
        o_misalign = (i_addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/data_mem_resp.sv
// Memory responder on the core's load/store port. Accepts one request at a
// time, performs it against an on-chip RAM and presents the response LATENCY
// cycles after the accept cycle.
//   clk    single clock, all state on posedge
//   rst    asynchronous, active-high reset
//   bus    slave side of data_mem_resp_if
// Parameters: DEPTH_LOG2 (RAM words = 2**DEPTH_LOG2), LATENCY (1..15),
// BASE_ADDR (byte address of word 0).
// Build option: define MEM_RESP_ERR_EN to report misaligned, undefined-size
// and out-of-range accesses through resp_err (store suppressed, rdata 0).
// Without it resp_err is 0, low address bits are ignored as needed,
// undefined sizes act as words and addresses wrap over the RAM.
module data_mem_resp
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR
) (
  input logic             clk,
  input logic             rst,
  data_mem_resp_if.slave  bus
);

  localparam int unsigned Words = 2 ** DEPTH_LOG2;

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic        r_wen;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_ram [Words];

  logic        w_acc_wen;
  logic [2:0]  w_acc_funct3;
  logic [31:0] w_acc_addr;
  logic [31:0] w_acc_wdata;
  logic [31:0] w_off;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [31:0] w_raw;
  logic [3:0]  w_be;
  logic [31:0] w_lane_wdata;
  logic [31:0] w_load_rdata;
  logic        w_misalign;
  logic        w_fault;
  logic        w_access;
  logic [31:0] w_resp_rdata;
  logic        w_unused_bits;

  // With LATENCY=1 the access happens on the accept edge, before anything is
  // latched, so the live request is used while IDLE.
  assign w_acc_wen    = (r_state == IDLE) ? bus.req_wen    : r_wen;
  assign w_acc_funct3 = (r_state == IDLE) ? bus.req_funct3 : r_funct3;
  assign w_acc_addr   = (r_state == IDLE) ? bus.req_addr   : r_addr;
  assign w_acc_wdata  = (r_state == IDLE) ? bus.req_wdata  : r_wdata;

  assign w_off = w_acc_addr - BASE_ADDR;
  assign w_idx = w_off[DEPTH_LOG2+1:2];
  assign w_raw = r_ram[w_idx];

  mem_lane_align u_lane (
    .i_funct3   (w_acc_funct3),
    .i_addr_lo  (w_acc_addr[1:0]),
    .i_wdata    (w_acc_wdata),
    .i_raw_word (w_raw),
    .o_be       (w_be),
    .o_wdata    (w_lane_wdata),
    .o_rdata    (w_load_rdata),
    .o_misalign (w_misalign)
  );

`ifdef MEM_RESP_ERR_EN
  assign w_fault = w_misalign
                 || (w_acc_funct3 inside {3'b011, 3'b110, 3'b111})
                 || (w_off[31:DEPTH_LOG2+2] != '0);
  assign w_unused_bits = ^w_off[1:0];
`else
  assign w_fault = 1'b0;
  assign w_unused_bits = ^{w_misalign, w_off[31:DEPTH_LOG2+2], w_off[1:0]};
`endif

  // The one edge that enters RESP is the only edge touching the RAM.
  assign w_access = ((r_state == IDLE) && bus.req_valid && (LATENCY == 1))
                 || ((r_state == WAIT) && (r_cnt == 4'd1));

  assign w_resp_rdata = (w_acc_wen || w_fault) ? 32'h0 : w_load_rdata;

  // RAM is deliberately not reset; reset on an access edge blocks the write.
  always_ff @(posedge clk) begin
    if (w_access && w_acc_wen && !w_fault && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_ram[w_idx][8*b +: 8] <= w_lane_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_wen        <= 1'b0;
      r_funct3     <= 3'b000;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_rdata      <= 32'h0;
      r_err        <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_wen       <= bus.req_wen;
            r_funct3    <= bus.req_funct3;
            r_addr      <= bus.req_addr;
            r_wdata     <= bus.req_wdata;
            r_cnt       <= 4'(LATENCY - 1);
            r_req_ready <= 1'b0;
            if (LATENCY == 1) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_rdata      <= w_resp_rdata;
              r_err        <= w_fault;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          // Counter reaching 0 on this edge marks the access edge.
          if (r_cnt == 4'd1) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_rdata      <= w_resp_rdata;
            r_err        <= w_fault;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

endmodule
